serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 178 +++++++++++++++++
 tb/tb_serial_adder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial add/subtract unit. Each cycle in RUN one operand bit pair and
//   the running carry pass through a full adder built from two half-adder
//   cells. After WIDTH cycles the result, carry and signed-overflow flags are
//   published together with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   start      operation request, sampled only in IDLE
//   sub        0 = a+b, 1 = a-b, sampled with start
//   a_in       operand A, sampled with start
//   b_in       operand B, sampled with start
//   busy       high while the operation is running
//   done       one-cycle pulse when result/flags are updated
//   result     last completed result, held until the next completion
//   carry_out  carry out of the MSB (sub mode: 1 = no borrow)
//   overflow   signed two's-complement overflow of the last operation
// -----------------------------------------------------------------------------

// Half-adder cell: sum and carry of two bits.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_carry;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic               w_s1;
    logic               w_c1;
    logic               w_sum;
    logic               w_c2;
    logic               w_cnext;
    logic               w_last;
    logic [WIDTH-1:0]   w_s_shift;

    // Full adder from two half-adder cells.
    half_adder u_ha1 (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    half_adder u_ha2 (
        .i_a (w_s1),
        .i_b (r_carry),
        .o_s (w_sum),
        .o_c (w_c2)
    );

    assign w_cnext   = w_c1 | w_c2;
    assign w_last    = (r_cnt == LAST);
    assign w_s_shift = {w_sum, r_s[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with it
    // without a decode path on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_RUN);
            r_done <= (w_next == S_DONE);
        end
    end

    // Datapath: operand load, serial add, and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction as a + ~b + 1: invert B, seed carry with 1.
                        r_a     <= a_in;
                        r_b     <= sub ? ~b_in : b_in;
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_s     <= w_s_shift;
                    r_carry <= w_cnext;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= w_s_shift;
                        r_cout   <= w_cnext;
                        // r_carry still holds the carry into the MSB here.
                        r_ovf    <= r_carry ^ w_cnext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    // Last result the DUT is expected to be holding.
    logic [7:0] held_r = 8'h00;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [7:0] r, output logic c, output logic v);
        int u;
        int sa;
        int sb;
        int sr;
        u  = s ? (int'(a) + 256 - int'(b)) : (int'(a) + int'(b));
        r  = u[7:0];
        c  = (u > 255);
        sa = (a > 8'd127) ? int'(a) - 256 : int'(a);
        sb = (b > 8'd127) ? int'(b) - 256 : int'(b);
        sr = s ? (sa - sb) : (sa + sb);
        v  = (sr > 127) || (sr < -128);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] er;
        logic       ec;
        logic       ev;
        int         lat;
        model(a, b, s, er, ec, ev);
        start = 1'b1; a_in = a; b_in = b; sub = s;
        @(posedge clk); #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom; sub = $urandom;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (!done) begin
                chk("busy_run", busy, 1);
                chk("held_result", result, held_r);
            end
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("done_latency", lat, 8);
        chk("busy_with_done", busy, 0);
        chk("result", result, er);
        chk("carry_out", carry_out, ec);
        chk("overflow", overflow, ev);
        held_r = er;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after", busy, 0);
        chk("result_held", result, er);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a_in = 8'h00; b_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_carry", carry_out, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        do_op(8'h5A, 8'h3C, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h10, 8'h20, 1'b1);
        do_op(8'h80, 8'h01, 1'b1);
        chk("dir_last_result", result, 8'h7F);

        // start held high for 30 edges: completions after edges 8, 18, 28
        start = 1'b1; a_in = 8'h01; b_in = 8'h02; sub = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            chk("held_start_done", done, (k == 8 || k == 18 || k == 28));
            if (done) chk("held_start_result", result, 8'h03);
        end
        start = 1'b0;
        held_r = 8'h03;
        repeat (12) @(posedge clk);
        #1;
        chk("held_idle_busy", busy, 0);

        // start pulsed mid-RUN with different operands must be ignored
        start = 1'b1; a_in = 8'h21; b_in = 8'h13; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("midrun_busy", busy, 1);
            chk("midrun_done", done, 0);
            if (k == 3) begin
                start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("midrun_done_pulse", done, 1);
        chk("midrun_result", result, 8'h34);
        chk("midrun_carry", carry_out, 0);
        held_r = 8'h34;
        @(posedge clk); #1;
        chk("midrun_idle", busy, 0);
        @(posedge clk); #1;
        chk("midrun_no_restart", busy, 0);

        // Asynchronous reset while processing bit 4
        do_op(8'hC3, 8'h5A, 1'b0);
        start = 1'b1; a_in = 8'h5A; b_in = 8'h3C; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 8'h00);
        chk("arst_carry", carry_out, 0);
        chk("arst_ovf", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        held_r = 8'h00;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk("arst_no_done", done, 0);
        end
        do_op(8'h12, 8'h34, 1'b0);

        // Randomized vectors
        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the flow above wedges.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
